// File: rtl/pipeline_interlock.sv
// Hazard and branch-shadow interlock for the 5-stage pipeline.
// Decides per cycle whether the ID instruction issues, stalls or is squashed.
module pipeline_interlock #(
    parameter int REG_NUM_W        = 5,
    parameter int BR_SHADOW_LEN    = 3,
    parameter int RF_WRITE_THROUGH = 0,
    parameter int CNT_W            = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 idValid,
    input  logic [REG_NUM_W-1:0] idRS,
    input  logic [REG_NUM_W-1:0] idRT,
    input  logic                 idUsesRS,
    input  logic                 idUsesRT,
    input  logic                 idRfWrEnable,
    input  logic [REG_NUM_W-1:0] idWrNum,
    input  logic                 idIsBranch,
    output logic                 stall,
    output logic                 bubble,
    output logic                 squash,
    output logic                 issue,
    output logic [CNT_W-1:0]     stallCount,
    output logic [CNT_W-1:0]     squashCount
);

    localparam int   SH_W   = $clog2(BR_SHADOW_LEN + 2);
    localparam logic WB_CHK = (RF_WRITE_THROUGH == 0);
    localparam logic SH_EN  = (BR_SHADOW_LEN > 0);

    typedef enum logic {
        S_RUN,
        S_SHADOW
    } state_e;

    state_e               state_q, state_d;
    logic [SH_W-1:0]      sh_cnt_q, sh_cnt_d;

    logic                 ex_v_q, ex_v_d;
    logic [REG_NUM_W-1:0] ex_n_q, ex_n_d;
    logic                 mem_v_q, mem_v_d;
    logic [REG_NUM_W-1:0] mem_n_q, mem_n_d;
    logic                 wb_v_q, wb_v_d;
    logic [REG_NUM_W-1:0] wb_n_q, wb_n_d;

    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     squash_cnt_q, squash_cnt_d;

    logic                 hit_rs;
    logic                 hit_rt;
    logic                 hazard;

    // Source registers matched against destinations still in flight
    always_comb begin
        hit_rs = (idRS != '0) &&
                 ((ex_v_q && ex_n_q == idRS) ||
                  (mem_v_q && mem_n_q == idRS) ||
                  (WB_CHK && wb_v_q && wb_n_q == idRS));
        hit_rt = (idRT != '0) &&
                 ((ex_v_q && ex_n_q == idRT) ||
                  (mem_v_q && mem_n_q == idRT) ||
                  (WB_CHK && wb_v_q && wb_n_q == idRT));
        hazard = idValid &&
                 ((idUsesRS && hit_rs) || (idUsesRT && hit_rt));
    end

    // Run/shadow control: issue decision and shadow countdown
    always_comb begin
        state_d  = state_q;
        sh_cnt_d = sh_cnt_q;
        stall    = 1'b0;
        squash   = 1'b0;
        issue    = 1'b0;
        unique case (state_q)
            S_RUN: begin
                stall = hazard;
                issue = idValid && !hazard;
                if (issue && idIsBranch && SH_EN) begin
                    state_d  = S_SHADOW;
                    sh_cnt_d = SH_W'(BR_SHADOW_LEN);
                end
            end
            S_SHADOW: begin
                squash = 1'b1;
                if (sh_cnt_q == SH_W'(1)) begin
                    state_d  = S_RUN;
                    sh_cnt_d = '0;
                end else begin
                    sh_cnt_d = sh_cnt_q - SH_W'(1);
                end
            end
            default: begin
                state_d  = S_RUN;
                sh_cnt_d = '0;
            end
        endcase
        bubble = stall || squash || !idValid;
    end

    // Destination scoreboard shifts every cycle; only issued writers enter
    always_comb begin
        ex_v_d  = issue && idRfWrEnable && (idWrNum != '0);
        ex_n_d  = ex_v_d ? idWrNum : '0;
        mem_v_d = ex_v_q;
        mem_n_d = ex_n_q;
        wb_v_d  = mem_v_q;
        wb_n_d  = mem_n_q;
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (squash && squash_cnt_q != '1) begin
            squash_cnt_d = squash_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_RUN;
            sh_cnt_q     <= '0;
            ex_v_q       <= 1'b0;
            ex_n_q       <= '0;
            mem_v_q      <= 1'b0;
            mem_n_q      <= '0;
            wb_v_q       <= 1'b0;
            wb_n_q       <= '0;
            stall_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            sh_cnt_q     <= sh_cnt_d;
            ex_v_q       <= ex_v_d;
            ex_n_q       <= ex_n_d;
            mem_v_q      <= mem_v_d;
            mem_n_q      <= mem_n_d;
            wb_v_q       <= wb_v_d;
            wb_n_q       <= wb_n_d;
            stall_cnt_q  <= stall_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign stallCount  = stall_cnt_q;
    assign squashCount = squash_cnt_q;

endmodule

// File: doc/pipeline_interlock.md
# pipeline_interlock

Hazard and branch-shadow controller for the 5-stage pipelined CPU (IF/ID/EX/MEM/WB, register file read in ID and written in WB, branches resolved in MEM). Each cycle it decides whether the instruction in ID issues, stalls, or is squashed. It drives the hold and bubble controls of the PC, IFID and IDEX pipeline registers, replacing the constant-false hazard signal. It keeps a destination-register scoreboard and a branch-shadow state machine, plus saturating stall and squash counters for performance monitoring.

## Interface
Parameters:
- `REG_NUM_W`, 5: register-number width.
- `BR_SHADOW_LEN`, 3: ID-stage slots squashed after a branch-class instruction issues. 0 disables the shadow.
- `RF_WRITE_THROUGH`, 0: 1 means the register file forwards the WB write to same-cycle reads, so the WB scoreboard entry is ignored.
- `CNT_W`, 16: performance-counter width.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `idValid` in 1: ID holds a real instruction.
- `idRS`, `idRT` in REG_NUM_W: source register numbers.
- `idUsesRS`, `idUsesRT` in 1: the instruction reads that source.
- `idRfWrEnable` in 1: the instruction writes the register file.
- `idWrNum` in REG_NUM_W: destination register (RT or RD, already selected).
- `idIsBranch` in 1: branch or jump class (decoder PC-write enable).
- `stall` out 1: hold PC and IFID this cycle.
- `bubble` out 1: IDEX loads a NOP (all enables 0) this cycle.
- `squash` out 1: the instruction in ID is wrong-path.
- `issue` out 1: the instruction in ID advances to EX this cycle.
- `stallCount` out CNT_W: cycles with `stall`=1, saturating.
- `squashCount` out CNT_W: cycles with `squash`=1, saturating.

## Operation
- Scoreboard: three entries {valid, num}, named EX, MEM and WB, mirroring the destinations in flight. At each edge WB<=MEM and MEM<=EX.
  - EX<={1, idWrNum} when `issue` & idRfWrEnable & idWrNum!=0.
  - Otherwise EX<={0, x}.
- Match(r) = r!=0 & (EX.valid&EX.num==r | MEM.valid&MEM.num==r | (!RF_WRITE_THROUGH & WB.valid&WB.num==r)).
- hazard = idValid & (idUsesRS&Match(idRS) | idUsesRT&Match(idRT)).
- State machine, two states:
  - RUN: squash=0; stall=hazard; issue=idValid&!hazard.
  - SHADOW: squash=1; stall=0; issue=0. A counter `shCnt` counts down.
- Transitions:
  - RUN to SHADOW at an edge where `issue`&idIsBranch and BR_SHADOW_LEN>0; load shCnt=BR_SHADOW_LEN.
  - In SHADOW, each edge decrements shCnt. When shCnt==1 at the edge, go to RUN.
- bubble = stall | squash | !idValid.
- Squashed instructions never enter the scoreboard. The scoreboard keeps shifting during stall and SHADOW.
- A branch with a RAW hazard stalls first. Its shadow starts only at its issue edge.
- Counters increment by 1 per qualifying cycle and hold at 2^CNT_W-1.

## Timing
- stall, bubble, squash and issue are combinational from state and same-cycle ID inputs. There is no registered output latency.
- Reset (`rst`=0 at an edge):
  - all scoreboard entries invalid;
  - state RUN, shCnt=0;
  - counters 0.
- Outputs in the cycle after reset: stall=0, squash=0, issue=idValid, bubble=!idValid.
- Reset mid-SHADOW or mid-stall aborts it: the next cycle is RUN with an empty scoreboard.
- Consumer at distance 1 from its producer (RF_WRITE_THROUGH=0): stalls 3 cycles, issues in the 4th.
- Same case with RF_WRITE_THROUGH=1: stalls 2 cycles.
- Distance 2 gives 2 or 1 stall cycles; distance 3 gives 1 or 0.
- A branch issuing at edge t squashes the ID slots in cycles t+1 through t+BR_SHADOW_LEN. The first possible issue is cycle t+BR_SHADOW_LEN+1.
- Writes to register 0 never create a hazard.
- Counters update at the edge ending the qualifying cycle and are visible the next cycle.

## Test plan
- Reset: hold rst=0 for 2 cycles with idValid=1 -> stall=0, squash=0, issue=1, stallCount=0, squashCount=0.
- RAW, no write-through:
  - Stimulus: issue a write to r3, then present a reader with idRS=3, idUsesRS=1.
  - Required: stall=1 and bubble=1 for exactly 3 cycles, issue=1 in the 4th, stallCount=3.
  - Repeat with RF_WRITE_THROUGH=1 -> 2 stall cycles.
- r0 and unused sources:
  - Producer writes r0, consumer reads r0 -> no stall.
  - Producer writes r5, consumer has idRT=5 but idUsesRT=0 -> no stall.
- Branch shadow:
  - Stimulus: issue idIsBranch=1 with BR_SHADOW_LEN=3.
  - Required: squash=1, issue=0 and bubble=1 for 3 cycles, then RUN; squashCount=3.
- Branch with hazard: a branch reads a register written 1 cycle earlier -> 3 stall cycles, then issue, then 3 squash cycles; stallCount=3, squashCount=3.
- Reset mid-operation:
  - Stimulus: pull rst low during the 2nd shadow cycle, with a pending write to r7 in the scoreboard.
  - Required: next cycle squash=0, and a reader of r7 issues with no stall.
